// File: rtl/keypad_event_gen.sv
`default_nettype none
// ============================================================================
// keypad_event_gen : synchronise and debounce pushbuttons, reject multi-key
//                    presses, emit single-cycle key events with digit repeat.
// Revision: 1.0
// ============================================================================
module keypad_event_gen #(
  parameter int WIDTH        = 20,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pb,
  output logic [$clog2(WIDTH)-1:0] keycode,
  output logic                     key_valid,
  output logic                     key_held,
  output logic                     multi_err
);

  localparam int KW   = $clog2(WIDTH);
  localparam int M1   = (DEBOUNCE > REPEAT_DELAY) ? DEBOUNCE : REPEAT_DELAY;
  localparam int MAXV = (M1 > REPEAT_RATE) ? M1 : REPEAT_RATE;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [WIDTH-1:0] C_PB_ONE = WIDTH'(1);
  localparam logic [CW-1:0]    C_ONE    = CW'(1);
  localparam logic [CW-1:0]    C_DEB    = CW'(DEBOUNCE);
  localparam logic [CW-1:0]    C_DLY    = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0]    C_RATE   = CW'(REPEAT_RATE);
  localparam logic [CW-1:0]    C_SAT    = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEB_PRESS = 3'd1,
    S_PRESSED   = 3'd2,
    S_DEB_REL   = 3'd3,
    S_FLUSH     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sync1_q, pb_s_q;
  logic [KW-1:0]   key_q, key_d, keycode_q, keycode_d;
  logic [CW-1:0]   cnt_q, cnt_d, hold_q, hold_d;
  logic            rep_q, rep_d;
  logic            kv_q, kv_d, held_q, held_d, merr_q, merr_d;

  logic [KW-1:0]   w_cand;
  logic            w_none, w_one, w_multi, w_same, w_rep_en;
  logic [CW-1:0]   w_cnt_inc, w_hold_inc;

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pb_s_q[i]) w_cand = KW'(i);
    end
  end

  // x & (x-1) clears the lowest set bit, so a nonzero result means two or more keys
  assign w_none     = (pb_s_q == '0);
  assign w_multi    = ((pb_s_q & (pb_s_q - C_PB_ONE)) != '0);
  assign w_one      = !w_none && !w_multi;
  assign w_same     = w_one && (w_cand == key_q);
  assign w_rep_en   = (REPEAT_DELAY != 0) && (int'(keycode_q) < 16);
  assign w_cnt_inc  = (cnt_q == C_SAT) ? cnt_q : cnt_q + C_ONE;
  assign w_hold_inc = (hold_q == C_SAT) ? hold_q : hold_q + C_ONE;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    keycode_d = keycode_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    kv_d      = 1'b0;
    held_d    = held_q;
    merr_d    = merr_q;
    case (state_q)
      S_IDLE: begin
        held_d = 1'b0;
        merr_d = 1'b0;
        if (w_multi) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          merr_d  = 1'b1;
        end else if (w_one) begin
          state_d = S_DEB_PRESS;
          key_d   = w_cand;
          cnt_d   = C_ONE;
        end
      end
      S_DEB_PRESS: begin
        if (w_multi) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          merr_d  = 1'b1;
        end else if (w_same) begin
          if (cnt_q >= C_DEB) begin
            state_d   = S_PRESSED;
            kv_d      = 1'b1;
            keycode_d = key_q;
            held_d    = 1'b1;
            hold_d    = '0;
            rep_d     = 1'b0;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESSED: begin
        if (w_none) begin
          state_d = S_DEB_REL;
          cnt_d   = C_ONE;
        end else if (!w_same) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          held_d  = 1'b0;
          merr_d  = 1'b1;
        end else begin
          hold_d = w_hold_inc;
          // A blocked repeat keeps the counter at target so it fires next cycle
          if (w_rep_en && !kv_q && (w_hold_inc >= (rep_q ? C_RATE : C_DLY))) begin
            kv_d   = 1'b1;
            hold_d = '0;
            rep_d  = 1'b1;
          end
        end
      end
      S_DEB_REL: begin
        if (w_none) begin
          if (cnt_q >= C_DEB) begin
            state_d = S_IDLE;
            held_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end else if (w_same) begin
          state_d = S_PRESSED;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          held_d  = 1'b0;
          merr_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        held_d = 1'b0;
        merr_d = 1'b1;
        if (w_none) begin
          if (w_cnt_inc >= C_DEB) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            merr_d  = 1'b0;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      pb_s_q    <= '0;
      key_q     <= '0;
      keycode_q <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      rep_q     <= 1'b0;
      kv_q      <= 1'b0;
      held_q    <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= pb;
      pb_s_q    <= sync1_q;
      key_q     <= key_d;
      keycode_q <= keycode_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      kv_q      <= kv_d;
      held_q    <= held_d;
      merr_q    <= merr_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_valid = kv_q;
  assign key_held  = held_q;
  assign multi_err = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_gen.sv
`default_nettype none
// Directed bench for keypad_event_gen: pulse timing is recorded relative to the
// cycle pb changes, so edge k after the change is sample index k+1.
module tb_keypad_event_gen;

  logic        clk;
  logic        rst;
  logic [19:0] pb;
  logic [4:0]  keycode;
  logic        key_valid;
  logic        key_held;
  logic        multi_err;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int base    = 0;
  int dbl     = 0;
  int held_drop;
  logic prev_kv = 1'b0;
  int pulse_at[$];
  int pulse_code[$];

  keypad_event_gen dut (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .keycode   (keycode),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid) begin
        if (prev_kv) dbl++;
        pulse_at.push_back(cyc - base);
        pulse_code.push_back(int'(keycode));
      end
      if (!key_held) held_drop++;
      prev_kv = key_valid;
    end
  endtask

  task automatic clr();
    pulse_at.delete();
    pulse_code.delete();
    base = cyc;
  endtask

  function automatic int at(input int i);
    return (i < pulse_at.size()) ? pulse_at[i] : -1;
  endfunction

  function automatic int code(input int i);
    return (i < pulse_code.size()) ? pulse_code[i] : -1;
  endfunction

  initial begin
    rst = 1'b1;
    pb  = '0;
    tick(3);
    chk("rst_keycode", int'(keycode), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_merr", int'(multi_err), 0);
    rst = 1'b0;
    tick(2);

    // single press of key 5: pulse after edge 5, held falls 5 edges after release
    pb = 20'(1) << 5; clr();
    tick(5);
    chk("t1_early", pulse_at.size(), 0);
    tick(1);
    chk("t1_valid", int'(key_valid), 1);
    chk("t1_code", int'(keycode), 5);
    chk("t1_held", int'(key_held), 1);
    tick(1);
    chk("t1_width", int'(key_valid), 0);
    tick(3);
    pb = '0;
    tick(5);
    chk("t1_held_before", int'(key_held), 1);
    tick(1);
    chk("t1_held_after", int'(key_held), 0);
    chk("t1_count", pulse_at.size(), 1);
    chk("t1_when", at(0), 6);
    tick(5);

    // 2-cycle bounce on key 9 never qualifies
    pb = 20'(1) << 9; clr();
    tick(2);
    pb = '0;
    tick(10);
    chk("t2_count", pulse_at.size(), 0);
    chk("t2_held", int'(key_held), 0);
    chk("t2_merr", int'(multi_err), 0);

    // digit held 80 cycles: first pulse, +50, then every 10
    pb = 20'(1) << 3; clr();
    tick(80);
    pb = '0;
    tick(10);
    chk("t3_count", pulse_at.size(), 4);
    chk("t3_p0", at(0), 6);
    chk("t3_p1", at(1), 56);
    chk("t3_p2", at(2), 66);
    chk("t3_p3", at(3), 76);
    chk("t3_code0", code(0), 3);
    chk("t3_code3", code(3), 3);

    // control key W never repeats
    pb = 20'(1) << 16; clr();
    tick(80);
    pb = '0;
    tick(10);
    chk("t3w_count", pulse_at.size(), 1);
    chk("t3w_code", code(0), 16);

    // two keys together: flush, clears on the third NONE sample of pb_s
    pb = (20'(1) << 1) | (20'(1) << 2); clr();
    tick(6);
    chk("t4_merr_set", int'(multi_err), 1);
    chk("t4_held", int'(key_held), 0);
    pb = '0;
    tick(4);
    chk("t4_merr_hold", int'(multi_err), 1);
    tick(1);
    chk("t4_merr_clear", int'(multi_err), 0);
    chk("t4_count", pulse_at.size(), 0);
    tick(3);
    pb = 20'(1) << 2; clr();
    tick(6);
    chk("t4_after_count", pulse_at.size(), 1);
    chk("t4_after_when", at(0), 6);
    chk("t4_after_code", code(0), 2);
    pb = '0;
    tick(10);

    // 1-cycle drop during hold is a bounce
    pb = 20'(1) << 7; clr();
    tick(10);
    pb = '0;
    tick(1);
    pb = 20'(1) << 7;
    held_drop = 0;
    tick(12);
    chk("t5_held_drop", held_drop, 0);
    chk("t5_count", pulse_at.size(), 1);
    chk("t5_code", int'(keycode), 7);
    pb = '0;
    tick(10);

    // reset during debounce
    pb = 20'(1) << 4; clr();
    tick(3);
    rst = 1'b1; pb = '0;
    tick(1);
    chk("t6a_valid", int'(key_valid), 0);
    chk("t6a_held", int'(key_held), 0);
    rst = 1'b0;
    tick(8);
    chk("t6a_count", pulse_at.size(), 0);

    // reset while held with a repeat pending
    pb = 20'(1) << 4; clr();
    tick(46);
    rst = 1'b1; pb = '0;
    tick(1);
    chk("t6b_valid", int'(key_valid), 0);
    chk("t6b_held", int'(key_held), 0);
    chk("t6b_code", int'(keycode), 0);
    chk("t6b_merr", int'(multi_err), 0);
    rst = 1'b0;
    tick(20);
    chk("t6b_count", pulse_at.size(), 1);

    pb = 20'(1) << 11; clr();
    tick(5);
    chk("t6c_early", pulse_at.size(), 0);
    tick(1);
    chk("t6c_valid", int'(key_valid), 1);
    chk("t6c_code", int'(keycode), 11);
    pb = '0;
    tick(10);

    chk("no_back_to_back", dbl, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
